sram_march_bist: RTL and testbench



---
 rtl/sram_march_bist_if.sv | 31 +++
 rtl/sram_march_bist.sv | 229 ++++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_march_bist_if.sv
// sram_march_bist_if: bundles the controller's SRAM pins (cen/gwen/wen/addr/din/q)
// together with its start/status signals. The BIST controller connects through the
// master modport. The SRAM macro side and the status consumer connect through the
// slave modport.
interface sram_march_bist_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic                  cen;
   logic                  gwen;
   logic [DATA_WIDTH-1:0] wen;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] q;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [ADDR_WIDTH-1:0] fail_addr;
   logic [7:0]            fail_count;

   modport master (
      input  start, q,
      output cen, gwen, wen, addr, din, busy, done, pass, fail_addr, fail_count
   );

   modport slave (
      output start, q,
      input  cen, gwen, wen, addr, din, busy, done, pass, fail_addr, fail_count
   );
endinterface

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- self-test controller for one gf180mcu SRAM macro.
// Element sequence: M0 up w0, M1 up (r0,w1), M2 up (r1,w0), M3 down (r0,w1),
// M4 down (r1,w0), M5 down r0. The DRAIN state performs the final compare.
// A test lasts 10N+1 busy cycles.
// All SRAM-facing outputs are driven straight from flops.
// Read data is checked one cycle after its read edge through a small
// expected-value/address/valid pipe.
// Optional feature macro: SRAM_BIST_FAIL_LOG_EN. When it is defined, the block
// records the address of the first mismatch and a saturating mismatch count.
// When it is not defined, fail_addr and fail_count are tied to 0.
module sram_march_bist #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   sram_march_bist_if.master bus
);

   typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

   state_t                state;
   logic                  cen;
   logic                  gwen;
   logic                  bg;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  busy;
   logic                  done;
   logic                  pass;

   logic                  launch;
   logic                  rd_issue;
   logic                  rd_exp;
   logic                  mismatch;

   logic                  vld_p1;
   logic                  exp_p1;

   // Ascending elements walk 0 -> N-1; the others walk N-1 -> 0.
   function automatic logic is_up(input state_t s);
      return (s == M0) || (s == M1) || (s == M2);
   endfunction

   // Background written by the second half of a read/write element.
   function automatic logic write_bg(input state_t s);
      return (s == M1) || (s == M3);
   endfunction

   function automatic state_t next_elem(input state_t s);
      state_t n;
      n = IDLE;
      case (s)
         M0:      n = M1;
         M1:      n = M2;
         M2:      n = M3;
         M3:      n = M4;
         M4:      n = M5;
         default: n = IDLE;
      endcase
      return n;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] elem_first(input state_t s);
      return is_up(s) ? ADDR_FIRST : ADDR_LAST;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] elem_last(input state_t s);
      return is_up(s) ? ADDR_LAST : ADDR_FIRST;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] step(input state_t s,
                                                   input logic [ADDR_WIDTH-1:0] a);
      return is_up(s) ? a + 1'b1 : a - 1'b1;
   endfunction

   // start is honoured only while idle or parked in DONE.
   assign launch   = bus.start && ((state == IDLE) || (state == DONE));
   // A read is exactly a cycle with the macro enabled and the write strobe high.
   assign rd_issue = !cen && gwen;
   // r1 reads happen only in M2 and M4. Every other read expects background 0.
   assign rd_exp   = (state == M2) || (state == M4);
   assign mismatch = vld_p1 && (bus.q != {DATA_WIDTH{exp_p1}});

   // March sequencer: element, address, and registered SRAM controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cen   <= 1'b1;
         gwen  <= 1'b1;
         bg    <= 1'b0;
         addr  <= ADDR_FIRST;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (launch) begin
                  state <= M0;
                  cen   <= 1'b0;
                  gwen  <= 1'b0;
                  bg    <= 1'b0;
                  addr  <= ADDR_FIRST;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            M0: begin
               if (addr == ADDR_LAST) begin
                  state <= M1;
                  addr  <= elem_first(M1);
                  gwen  <= 1'b1;
               end else begin
                  addr <= step(state, addr);
               end
            end
            M1, M2, M3, M4: begin
               if (gwen) begin
                  // The read was just issued. Rewrite the same word with the new background.
                  gwen <= 1'b0;
                  bg   <= write_bg(state);
               end else begin
                  gwen <= 1'b1;
                  if (addr == elem_last(state)) begin
                     state <= next_elem(state);
                     addr  <= elem_first(next_elem(state));
                  end else begin
                     addr <= step(state, addr);
                  end
               end
            end
            M5: begin
               if (addr == ADDR_FIRST) begin
                  state <= DRAIN;
                  cen   <= 1'b1;
               end else begin
                  addr <= addr - 1'b1;
               end
            end
            DRAIN: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               cen   <= 1'b1;
               gwen  <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Compare pipe: remember what the read issued this cycle should return.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         exp_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_issue;
         exp_p1 <= rd_exp;
      end
   end

   // Pass flag: set on launch, cleared for good by the first mismatch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass <= 1'b0;
      end else if (launch) begin
         pass <= 1'b1;
      end else if (mismatch) begin
         pass <= 1'b0;
      end
   end

`ifdef SRAM_BIST_FAIL_LOG_EN
   logic [ADDR_WIDTH-1:0] cmp_addr_p1;
   logic [ADDR_WIDTH-1:0] fail_addr;
   logic [7:0]            fail_count;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Address companion of the compare pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_addr_p1 <= ADDR_FIRST;
      end else if (rd_issue) begin
         cmp_addr_p1 <= addr;
      end
   end

   // Failure log: the first failing address (while pass is still set) and a saturating count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_addr  <= ADDR_FIRST;
         fail_count <= 8'd0;
      end else if (launch) begin
         fail_addr  <= ADDR_FIRST;
         fail_count <= 8'd0;
      end else if (mismatch) begin
         if (pass) begin
            fail_addr <= cmp_addr_p1;
         end
         fail_count <= sat_inc(fail_count);
      end
   end

   assign bus.fail_addr  = fail_addr;
   assign bus.fail_count = fail_count;
`else
   assign bus.fail_addr  = '0;
   assign bus.fail_count = 8'd0;
`endif

   assign bus.cen  = cen;
   assign bus.gwen = gwen;
   assign bus.wen  = {DATA_WIDTH{gwen}};
   assign bus.addr = addr;
   assign bus.din  = {DATA_WIDTH{bg}};
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.pass = pass;

endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: 16x8 configuration of sram_march_bist attached to a
// behavioural SRAM with selectable faults.
// Fault modes: 0 none, 1 addr5 bit3 stuck-at-0, 2 write to addr2 puts ~din
// into addr9, 3 addr15 bit7 stuck-at-1, 4 every read returns 0.
module tb_sram_march_bist;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 1 << AW;
`ifdef SRAM_BIST_FAIL_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   fault;

   sram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: synchronous write/read, q valid after the read edge.
   logic [DW-1:0] mem [N];

   function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = mem[a];
      if (fault == 1 && a == 4'd5)  v = v & 8'hF7;
      if (fault == 3 && a == 4'd15) v = v | 8'h80;
      if (fault == 4)               v = 8'h00;
      return v;
   endfunction

   always @(posedge clk) begin
      if (!bus.cen) begin
         if (!bus.gwen) begin
            mem[bus.addr] <= (mem[bus.addr] & bus.wen) | (bus.din & ~bus.wen);
            if (fault == 2 && bus.addr == 4'd2) mem[9] <= ~bus.din;
         end else begin
            bus.q <= rd(bus.addr);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected SRAM pins in busy cycle k, derived from the March C- element list.
   function automatic bit op_ok(input int k);
      int e;
      int j;
      int a;
      bit wr;
      logic [DW-1:0] d;
      logic [AW-1:0] ea;
      a = 0;
      wr = 1'b0;
      d = 8'h00;
      if (k < N) begin
         wr = 1'b1;
         a = k;
      end else if (k < 9 * N) begin
         e = (k - N) / (2 * N);
         j = (k - N) % (2 * N);
         a = (e < 2) ? j / 2 : N - 1 - j / 2;
         wr = (j % 2) == 1;
         d = (e == 0 || e == 2) ? 8'hFF : 8'h00;
      end else if (k < 10 * N) begin
         a = N - 1 - (k - 9 * N);
      end else begin
         return bus.cen === 1'b1;
      end
      ea = AW'(a);
      if (bus.cen !== 1'b0 || bus.addr !== ea) return 1'b0;
      if (wr) return bus.gwen === 1'b0 && bus.wen === 8'h00 && bus.din === d;
      return bus.gwen === 1'b1 && bus.wen === 8'hFF;
   endfunction

   // Pulse start, follow the run to completion, and record the first bad trace cycle.
   task automatic run_march(input bit poke40, output int cyc, output int bad);
      cyc = 0;
      bad = -1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (bus.busy && cyc < 2000) begin
         if (!op_ok(cyc) && bad < 0) bad = cyc;
         bus.start = (poke40 && cyc == 40);
         cyc++;
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   typedef struct {
      int fault;
      bit poke;
      int exp_pass;
      int exp_fa;
      int exp_fc;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int bad;
      tests = 0;
      fails = 0;
      fault = 0;

      vecs[0] = '{0, 1'b0, 1, 0, 0};
      vecs[1] = '{1, 1'b0, 0, LOG ? 5 : 0, LOG ? 2 : 0};
      vecs[2] = '{2, 1'b0, 0, LOG ? 9 : 0, LOG ? 2 : 0};
      vecs[3] = '{3, 1'b0, 0, LOG ? 15 : 0, LOG ? 3 : 0};
      vecs[4] = '{4, 1'b0, 0, 0, LOG ? 32 : 0};
      vecs[5] = '{0, 1'b1, 1, 0, 0};

      // Reset values
      rst_n = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cen", bus.cen, 1);
      check("rst_gwen", bus.gwen, 1);
      check("rst_wen", bus.wen, 8'hFF);
      check("rst_addr", bus.addr, 0);
      check("rst_din", bus.din, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_pass", bus.pass, 0);
      check("rst_fail_addr", bus.fail_addr, 0);
      check("rst_fail_count", bus.fail_count, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_cen", bus.cen, 1);

      // Table-driven full runs
      for (int i = 0; i < 6; i++) begin
         fault = vecs[i].fault;
         run_march(vecs[i].poke, cyc, bad);
         check($sformatf("v%0d_busy_cycles", i), cyc, 10 * N + 1);
         check($sformatf("v%0d_trace_first_bad", i), bad, -1);
         check($sformatf("v%0d_done", i), bus.done, 1);
         check($sformatf("v%0d_cen_done", i), bus.cen, 1);
         check($sformatf("v%0d_pass", i), bus.pass, vecs[i].exp_pass);
         check($sformatf("v%0d_fail_addr", i), bus.fail_addr, vecs[i].exp_fa);
         check($sformatf("v%0d_fail_count", i), bus.fail_count, vecs[i].exp_fc);
         @(negedge clk);
      end

      // done and pass are sticky in DONE
      fault = 0;
      repeat (5) @(negedge clk);
      check("sticky_done", bus.done, 1);
      check("sticky_pass", bus.pass, 1);
      check("sticky_busy", bus.busy, 0);
      check("sticky_gwen", bus.gwen, 1);

      // Mid-test asynchronous reset
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (49) @(negedge clk);
      check("mid_cen_active", bus.cen, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cen", bus.cen, 1);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_cen", bus.cen, 1);
      check("post_rst_busy", bus.busy, 0);
      run_march(1'b0, cyc, bad);
      check("post_rst_busy_cycles", cyc, 10 * N + 1);
      check("post_rst_trace", bad, -1);
      check("post_rst_pass", bus.pass, 1);

      // start held high: one restart per DONE sample
      bus.start = 1'b1;
      @(negedge clk);
      check("held_first_busy", bus.busy, 1);
      cyc = 0;
      while (bus.busy && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
      check("held_busy_cycles", cyc, 10 * N + 1);
      check("held_done", bus.done, 1);
      @(negedge clk);
      check("held_restart_busy", bus.busy, 1);
      check("held_restart_done", bus.done, 0);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
      check("held_second_cycles", cyc, 10 * N + 1);
      check("held_second_pass", bus.pass, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
